// File: rtl/riscv_id_ex_stage.sv
// rtl/riscv_id_ex_stage.sv - ID/EX pipeline register with load-use stall and EX operand select
module riscv_id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               flush,
    input  logic [1:0]         forwardA,
    input  logic [1:0]         forwardB,
    input  logic [XLEN-1:0]    wb_result,
    output logic               stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [XLEN-1:0]    ex_op_a,
    output logic [XLEN-1:0]    ex_op_b,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg
);

    localparam logic [1:0] FWD_WB = 2'b10;

    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic            alu_src_q;
    logic            kill;
    logic            take;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A load in EX whose destination is read by ID cannot forward in time; rs fields
    // are compared even if unused, which can only add harmless extra stalls.
    assign stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Flush and stall both turn the ID slot into a bubble; ID is re-presented after a stall.
    assign kill = flush | stall;
    assign take = id_valid & ~kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            ex_alu_op     <= '0;
            alu_src_q     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            ex_valid      <= take;
            ex_mem_read   <= take & id_mem_read;
            ex_mem_write  <= take & id_mem_write;
            ex_reg_write  <= take & id_reg_write;
            ex_mem_to_reg <= take & id_mem_to_reg;
            ex_pc         <= kill ? '0 : id_pc;
            ex_rs1        <= kill ? '0 : id_rs1;
            ex_rs2        <= kill ? '0 : id_rs2;
            ex_rd         <= kill ? '0 : id_rd;
            rs1_data_q    <= kill ? '0 : id_rs1_data;
            rs2_data_q    <= kill ? '0 : id_rs2_data;
            imm_q         <= kill ? '0 : id_imm;
            ex_alu_op     <= kill ? '0 : id_alu_op;
            alu_src_q     <= kill ? 1'b0 : id_alu_src;
        end
    end

    // Only the WB path is selectable here; other codes fall back to register data.
    assign fwd_a = (forwardA == FWD_WB) ? wb_result : rs1_data_q;
    assign fwd_b = (forwardB == FWD_WB) ? wb_result : rs2_data_q;

    assign ex_op_a       = fwd_a;
    assign ex_op_b       = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// tb/tb_riscv_id_ex_stage.sv - scoreboard bench for riscv_id_ex_stage against a reference model
module tb_riscv_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  op;
        logic        src, mr, mw, rw, m2r;
    } ex_t;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, sd;
        logic [3:0]  op;
        logic        mr, mw, rw, m2r;
    } exp_t;

    bit          clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic        flush;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] wb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_store_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

    exp_t sb[$];
    ex_t  mdl;
    logic last_stall;
    int   n_cmp;
    int   n_err;

    riscv_id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .forwardA(forwardA), .forwardB(forwardB), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
        .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic load_use();
        return id_valid && mdl.valid && mdl.mr && (mdl.rd != 5'd0) &&
               (mdl.rd == id_rs1 || mdl.rd == id_rs2);
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] fb;
        fb      = (forwardB == 2'b10) ? wb_result : mdl.d2;
        e.stall = load_use();
        e.valid = mdl.valid;
        e.pc    = mdl.pc;
        e.rs1   = mdl.rs1;
        e.rs2   = mdl.rs2;
        e.rd    = mdl.rd;
        e.a     = (forwardA == 2'b10) ? wb_result : mdl.d1;
        e.b     = mdl.src ? mdl.imm : fb;
        e.sd    = fb;
        e.op    = mdl.op;
        e.mr    = mdl.mr;
        e.mw    = mdl.mw;
        e.rw    = mdl.rw;
        e.m2r   = mdl.m2r;
        return e;
    endfunction

    function automatic ex_t advance();
        ex_t n;
        n = '0;
        if (!(flush || load_use())) begin
            n.valid = id_valid;
            n.pc    = id_pc;
            n.rs1   = id_rs1;
            n.rs2   = id_rs2;
            n.rd    = id_rd;
            n.d1    = id_rs1_data;
            n.d2    = id_rs2_data;
            n.imm   = id_imm;
            n.op    = id_alu_op;
            n.src   = id_alu_src;
            n.mr    = id_mem_read & id_valid;
            n.mw    = id_mem_write & id_valid;
            n.rw    = id_reg_write & id_valid;
            n.m2r   = id_mem_to_reg & id_valid;
        end
        return n;
    endfunction

    task automatic cycle();
        ex_t nxt;
        sb.push_back(predict());
        nxt        = advance();
        last_stall = load_use();
        @(posedge clk);
        #1;
        mdl = nxt;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
        id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        id_mem_to_reg = 0; flush = 0; forwardA = 0; forwardB = 0; wb_result = 0;
    endtask

    task automatic rand_id();
        id_valid      = ($urandom_range(0, 3) != 0);
        id_pc         = $urandom;
        id_rs1        = 5'($urandom_range(0, 4));
        id_rs2        = 5'($urandom_range(0, 4));
        id_rd         = 5'($urandom_range(0, 4));
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_alu_op     = 4'($urandom);
        id_alu_src    = 1'($urandom_range(0, 1));
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = 1'($urandom_range(0, 1));
        id_reg_write  = 1'($urandom_range(0, 1));
        id_mem_to_reg = 1'($urandom_range(0, 1));
    endtask

    // Monitor: every falling edge with a pending expectation is compared field by field.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall",         32'(stall),         32'(e.stall));
            chk("ex_valid",      32'(ex_valid),      32'(e.valid));
            chk("ex_pc",         ex_pc,              e.pc);
            chk("ex_rs1",        32'(ex_rs1),        32'(e.rs1));
            chk("ex_rs2",        32'(ex_rs2),        32'(e.rs2));
            chk("ex_rd",         32'(ex_rd),         32'(e.rd));
            chk("ex_op_a",       ex_op_a,            e.a);
            chk("ex_op_b",       ex_op_b,            e.b);
            chk("ex_store_data", ex_store_data,      e.sd);
            chk("ex_alu_op",     32'(ex_alu_op),     32'(e.op));
            chk("ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
            chk("ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
            chk("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
            chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_stall = 0;
        mdl = '0;
        clear_id();
        rst_n = 0;
        sb.push_back(predict());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Normal capture with immediate operand
        id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
        id_rs1_data = 32'h10; id_imm = 32'h4; id_alu_src = 1; id_reg_write = 1;
        cycle();
        clear_id();
        cycle();

        // Forwarding from WB, then store data forwarded while B takes the immediate
        id_valid = 1; id_rs1 = 6; id_rs2 = 7; id_rd = 8;
        id_rs1_data = 32'h5; id_rs2_data = 32'h6; id_imm = 32'h77; id_alu_src = 0;
        cycle();
        clear_id();
        forwardA = 2'b10; forwardB = 2'b00; wb_result = 32'hDEAD;
        cycle();
        id_valid = 1; id_rs2_data = 32'h6; id_imm = 32'h77; id_alu_src = 1; id_mem_write = 1;
        cycle();
        clear_id();
        forwardB = 2'b10; wb_result = 32'hDEAD;
        cycle();
        forwardA = 2'b01; forwardB = 2'b11;
        cycle();
        clear_id();

        // Load-use on rs2: one stall cycle, bubble, then capture
        id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
        cycle();
        clear_id();
        id_valid = 1; id_rs1 = 9; id_rs2 = 5; id_rd = 10; id_reg_write = 1; id_rs1_data = 32'h33;
        cycle();
        cycle();
        cycle();
        clear_id();

        // Load to x0 never stalls
        id_valid = 1; id_rd = 0; id_mem_read = 1;
        cycle();
        clear_id();
        id_valid = 1; id_rs1 = 0; id_reg_write = 1;
        cycle();
        clear_id();
        cycle();

        // Flush concurrent with stall
        id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
        cycle();
        clear_id();
        id_valid = 1; id_rs1 = 7; id_rd = 11; id_reg_write = 1; id_rs1_data = 32'h44;
        flush = 1;
        cycle();
        flush = 0;
        id_rs1 = 12;
        cycle();
        clear_id();
        cycle();

        // Asynchronous reset mid-cycle while a load-use stall is pending
        id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1; id_rs1_data = 32'h99;
        cycle();
        clear_id();
        id_valid = 1; id_rs2 = 5;
        #2;
        rst_n = 0;
        mdl = '0;
        sb.push_back(predict());
        @(posedge clk);
        #1;
        rst_n = 1;
        last_stall = 0;
        clear_id();

        // Randomized traffic; ID is held upstream whenever the model predicts a stall
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall)
                rand_id();
            flush     = ($urandom_range(0, 7) == 0);
            forwardA  = 2'($urandom);
            forwardB  = 2'($urandom);
            wb_result = $urandom;
            cycle();
        end

        for (int k = 0; k < 5 && sb.size() != 0; k++)
            @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_id_ex_stage.md
Name: riscv_id_ex_stage

Overview:
ID/EX pipeline register and EX-side operand select for the RV32I 5-stage core. It latches decoded instruction fields from ID, detects load-use hazards (stall plus bubble insertion) and honours branch flush. It also consumes the forwardA/forwardB codes from the forwarding unit to build the final ALU operands and store data for EX.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  ALUOP_W  ALU operation
id_alu_src  in  1  1 = operand B is immediate
id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control bits
flush  in  1  branch/jump taken in EX; kill ID instruction
forwardA, forwardB  in  2 each  forwarding-unit select codes for EX rs1/rs2
wb_result  in  XLEN  value being written back in WB
stall  out  1  load-use hazard; IF/ID must hold
ex_valid  out  1  EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices (feed forwarding unit)
ex_op_a, ex_op_b  out  XLEN each  final ALU operands
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_alu_op  out  ALUOP_W  registered ALU op
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control

Behaviour:
- Reset (rst_n low, async): all registered outputs 0, i.e. ex_valid=0, all control 0, indices 0, pc/data/imm 0. stall=0 while reset is asserted. Deassertion takes effect at the next clk edge.
- Hazard detect (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Rs fields are compared regardless of whether the instruction uses them; conservative stalls are permitted.
- Register update on each rising clk, priority flush > stall > load:
  - flush=1: bubble, i.e. ex_valid=0 and ex_mem_read/ex_mem_write/ex_reg_write/ex_mem_to_reg=0. Data fields are don't-care and are cleared to 0. flush overrides a concurrent stall.
  - stall=1: bubble, same as flush. The ID instruction is retained upstream and re-presented next cycle. Stall therefore lasts exactly 1 cycle per load-use pair.
  - otherwise: capture all id_* fields. Control bits are ANDed with id_valid, so an invalid ID produces a bubble.
- Operand select (combinational from registered state):
  - fwd_a = wb_result if forwardA==2'b10, else the registered rs1_data. Codes 00/01/11 select register data.
  - fwd_b is built the same way from forwardB and the registered rs2_data.
  - ex_op_a = fwd_a.
  - ex_op_b = registered imm if alu_src=1, else fwd_b.
  - ex_store_data = fwd_b, always forwarded even when alu_src=1.
- Register-file write-through is the register file's responsibility; this block performs no ID-side bypass.
- No latency beyond the pipeline register: ID fields appear on ex_* one cycle after capture.
- Reset mid-stall: outputs clear immediately and stall drops.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with ex_valid=1 -> ex_valid=0, ex_reg_write=0, ex_op_a=0 immediately, without waiting for a clk edge.
- Normal capture: id_valid=1, rs1_data=0x10, imm=0x4, alu_src=1, reg_write=1 -> next cycle ex_op_a=0x10, ex_op_b=0x4, ex_reg_write=1, ex_valid=1.
- Forwarding: EX holds rs1_data=0x5, rs2_data=0x6, alu_src=0. With forwardA=10, forwardB=00, wb_result=0xDEAD -> ex_op_a=0xDEAD, ex_op_b=0x6. With forwardB=10, alu_src=1 -> ex_store_data=0xDEAD and ex_op_b=imm.
- Load-use: EX=lw x5 (mem_read=1, rd=5), ID rs2=5 -> stall=1 same cycle. Next cycle ex_valid=0, stall=0. Re-presented ID instruction captured the cycle after.
- rd=x0 load: EX lw with rd=0, ID rs1=0 -> stall=0.
- Flush vs stall: flush=1 while stall=1 and id_valid=1 -> next cycle bubble (ex_valid=0, all control 0). The following cycle captures the new ID contents normally.
